serial_work_loader: RTL and testbench



---
 rtl/serial_work_loader.sv | 174 +++++++++++++++++
 tb/tb_serial_work_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_work_loader.sv
// Assembles a fixed-length work frame from a received byte stream, with optional sync byte and checksum.
// Frame commits 1 clk after the final byte strobe; an idle timeout aborts a partial frame.
module serial_work_loader #(
  parameter int unsigned PAYLOAD_BYTES  = 44,
  parameter int unsigned TIMEOUT_CYCLES = 8388608,
  parameter bit          SYNC_EN        = 1'b0,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter bit          CHECKSUM_EN    = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [8*PAYLOAD_BYTES-1:0] work_out,
  output logic                       load_flag,
  output logic                       load_pulse,
  output logic                       busy,
  output logic                       cksum_err,
  output logic                       timeout_err,
  output logic [7:0]                 error_count
);

  localparam int unsigned W  = 8 * PAYLOAD_BYTES;
  localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_PAYLOAD,
    S_CHECKSUM
  } state_e;

  localparam state_e START = SYNC_EN ? S_HUNT : S_PAYLOAD;

  state_e        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] to_q, to_d;
  logic [W-1:0]  work_q, work_d;
  logic          flag_q, flag_d;
  logic          lp_q, lp_d;
  logic          ce_q, ce_d;
  logic          te_q, te_d;
  logic [7:0]    ec_q, ec_d;

  logic          busy_w;
  logic          commit;
  logic [7:0]    ck_sum;
  logic [W+7:0]  shifted;

  assign busy_w = SYNC_EN ? (state_q != S_HUNT)
                          : ((cnt_q != '0) || (state_q == S_CHECKSUM));

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    to_d    = to_q;
    work_d  = work_q;
    flag_d  = flag_q;
    lp_d    = 1'b0;
    ce_d    = 1'b0;
    te_d    = 1'b0;
    ec_d    = ec_q;
    commit  = 1'b0;
    ck_sum  = sum_q + rx_data;
    shifted = {buf_q, rx_data};

    if (rx_valid) begin
      to_d = '0;
    end else if (busy_w) begin
      to_d = to_q + TW'(1);
    end

    case (state_q)
      S_HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_d = shifted[W-1:0];
          sum_d = ck_sum;
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (CHECKSUM_EN) begin
              state_d = S_CHECKSUM;
            end else begin
              commit = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CHECKSUM: begin
        if (rx_valid) begin
          if (ck_sum == 8'h00) begin
            commit = 1'b1;
          end else begin
            ce_d = 1'b1;
          end
          state_d = START;
          sum_d   = '0;
        end
      end
      default: state_d = START;
    endcase

    // A byte arriving on the expiry cycle keeps the frame alive.
    if (busy_w && !rx_valid && (to_q == TO_LAST)) begin
      te_d    = 1'b1;
      state_d = START;
      cnt_d   = '0;
      sum_d   = '0;
      to_d    = '0;
    end

    if (commit) begin
      work_d  = buf_d;
      flag_d  = ~flag_q;
      lp_d    = 1'b1;
      state_d = START;
      sum_d   = '0;
      to_d    = '0;
    end

    if ((ce_d || te_d) && (ec_q != 8'hFF)) begin
      ec_d = ec_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START;
      buf_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      to_q    <= '0;
      work_q  <= '0;
      flag_q  <= 1'b0;
      lp_q    <= 1'b0;
      ce_q    <= 1'b0;
      te_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      to_q    <= to_d;
      work_q  <= work_d;
      flag_q  <= flag_d;
      lp_q    <= lp_d;
      ce_q    <= ce_d;
      te_q    <= te_d;
      ec_q    <= ec_d;
    end
  end

  assign work_out    = work_q;
  assign load_flag   = flag_q;
  assign load_pulse  = lp_q;
  assign busy        = busy_w;
  assign cksum_err   = ce_q;
  assign timeout_err = te_q;
  assign error_count = ec_q;

endmodule

// File: tb/tb_serial_work_loader.sv
// Bench for serial_work_loader: four parameter sets, one active at a time, checked every cycle
// against a frame-level model built from byte queues and arithmetic checksums.
module tb_serial_work_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_d = 8'h00;
  logic       rx_v = 1'b0;
  int         cur = 0;
  int         n_chk = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  logic [351:0] work_a, work_b;
  logic [31:0]  work_c;
  logic [7:0]   work_d;
  logic         flag_a, lp_a, busy_a, ce_a, te_a;
  logic         flag_b, lp_b, busy_b, ce_b, te_b;
  logic         flag_c, lp_c, busy_c, ce_c, te_c;
  logic         flag_d, lp_d, busy_d, ce_d, te_d;
  logic [7:0]   ec_a, ec_b, ec_c, ec_d;

  serial_work_loader #(.PAYLOAD_BYTES(44), .TIMEOUT_CYCLES(16), .SYNC_EN(1'b0),
                       .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) u_a (
    .clk(clk), .reset(reset), .rx_data(rx_d), .rx_valid(rx_v && (cur == 0)),
    .work_out(work_a), .load_flag(flag_a), .load_pulse(lp_a), .busy(busy_a),
    .cksum_err(ce_a), .timeout_err(te_a), .error_count(ec_a));

  serial_work_loader #(.PAYLOAD_BYTES(44), .TIMEOUT_CYCLES(64), .SYNC_EN(1'b1),
                       .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .rx_data(rx_d), .rx_valid(rx_v && (cur == 1)),
    .work_out(work_b), .load_flag(flag_b), .load_pulse(lp_b), .busy(busy_b),
    .cksum_err(ce_b), .timeout_err(te_b), .error_count(ec_b));

  serial_work_loader #(.PAYLOAD_BYTES(4), .TIMEOUT_CYCLES(8), .SYNC_EN(1'b0),
                       .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1)) u_c (
    .clk(clk), .reset(reset), .rx_data(rx_d), .rx_valid(rx_v && (cur == 2)),
    .work_out(work_c), .load_flag(flag_c), .load_pulse(lp_c), .busy(busy_c),
    .cksum_err(ce_c), .timeout_err(te_c), .error_count(ec_c));

  serial_work_loader #(.PAYLOAD_BYTES(1), .TIMEOUT_CYCLES(2), .SYNC_EN(1'b1),
                       .SYNC_BYTE(8'h3C), .CHECKSUM_EN(1'b1)) u_d (
    .clk(clk), .reset(reset), .rx_data(rx_d), .rx_valid(rx_v && (cur == 3)),
    .work_out(work_d), .load_flag(flag_d), .load_pulse(lp_d), .busy(busy_d),
    .cksum_err(ce_d), .timeout_err(te_d), .error_count(ec_d));

  logic [351:0] o_work;
  logic         o_flag, o_lp, o_busy, o_ce, o_te;
  logic [7:0]   o_ec;

  always_comb begin
    o_work = '0; o_flag = 1'b0; o_lp = 1'b0; o_busy = 1'b0; o_ce = 1'b0; o_te = 1'b0; o_ec = '0;
    case (cur)
      0: begin o_work = work_a; o_flag = flag_a; o_lp = lp_a; o_busy = busy_a;
               o_ce = ce_a; o_te = te_a; o_ec = ec_a; end
      1: begin o_work = work_b; o_flag = flag_b; o_lp = lp_b; o_busy = busy_b;
               o_ce = ce_b; o_te = te_b; o_ec = ec_b; end
      2: begin o_work = {320'd0, work_c}; o_flag = flag_c; o_lp = lp_c; o_busy = busy_c;
               o_ce = ce_c; o_te = te_c; o_ec = ec_c; end
      3: begin o_work = {344'd0, work_d}; o_flag = flag_d; o_lp = lp_d; o_busy = busy_d;
               o_ce = ce_d; o_te = te_d; o_ec = ec_d; end
      default: ;
    endcase
  end

  // Reference model: active configuration plus frame-level state.
  int           P, T;
  bit           SY, CK;
  logic [7:0]   SB;
  logic [7:0]   fq[$];
  bit           synced;
  int           idle;
  logic [351:0] e_work;
  bit           e_flag, e_lp, e_ce, e_te;
  int           e_ec;

  task automatic chk(input string tag, input logic [351:0] got, input logic [351:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)", tag, got, exp, cur, $time);
    end
  endtask

  task automatic end_frame();
    fq.delete();
    synced = 1'b0;
    idle = 0;
  endtask

  task automatic bump_err();
    if (e_ec < 255) e_ec++;
  endtask

  task automatic commit_frame();
    e_work = '0;
    for (int i = 0; i < P; i++) e_work[8*(P-1-i) +: 8] = fq[i];
    e_flag = ~e_flag;
    e_lp = 1'b1;
    end_frame();
  endtask

  function automatic bit exp_busy();
    return SY ? synced : (fq.size() > 0);
  endfunction

  task automatic model(input bit v, input logic [7:0] b);
    bit active;
    int s;
    active = exp_busy();
    e_lp = 1'b0; e_ce = 1'b0; e_te = 1'b0;
    if (v) begin
      idle = 0;
      if (SY && !synced) begin
        synced = (b == SB);
      end else if (fq.size() < P) begin
        fq.push_back(b);
        if (fq.size() == P && !CK) commit_frame();
      end else begin
        s = int'(b);
        foreach (fq[i]) s += int'(fq[i]);
        if (s % 256 == 0) commit_frame();
        else begin e_ce = 1'b1; bump_err(); end
        end_frame();
      end
    end else if (active) begin
      idle++;
      if (idle >= T) begin e_te = 1'b1; bump_err(); end_frame(); end
    end
  endtask

  task automatic check_outputs();
    chk("work_out", o_work, e_work);
    chk("load_flag", 352'(o_flag), 352'(e_flag));
    chk("load_pulse", 352'(o_lp), 352'(e_lp));
    chk("busy", 352'(o_busy), 352'(exp_busy()));
    chk("cksum_err", 352'(o_ce), 352'(e_ce));
    chk("timeout_err", 352'(o_te), 352'(e_te));
    chk("error_count", 352'(o_ec), 352'(e_ec));
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    rx_v = v;
    rx_d = b;
    model(v, b);
    @(posedge clk);
    @(negedge clk);
    rx_v = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset(input int k);
    rx_v = 1'b0;
    reset = 1'b1;
    cur = k;
    case (k)
      0: begin P = 44; T = 16; SY = 0; CK = 0; SB = 8'hA5; end
      1: begin P = 44; T = 64; SY = 1; CK = 0; SB = 8'hA5; end
      2: begin P = 4;  T = 8;  SY = 0; CK = 1; SB = 8'hA5; end
      default: begin P = 1; T = 2; SY = 1; CK = 1; SB = 8'h3C; end
    endcase
    end_frame();
    e_work = '0; e_flag = 0; e_lp = 0; e_ce = 0; e_te = 0; e_ec = 0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic idle_gap();
    int gmax;
    int g;
    gmax = (T > 3) ? 2 : T - 1;
    g = ($urandom_range(0, 60) == 0) ? T : int'($urandom % unsigned'(gmax + 1));
    repeat (g) step(1'b0, 8'h00);
  endtask

  task automatic rand_frames(input int nf);
    logic [7:0] b;
    int s;
    for (int f = 0; f < nf; f++) begin
      if (SY) begin
        if ($urandom_range(0, 3) == 0) step(1'b1, 8'($urandom));
        step(1'b1, SB);
      end
      s = 0;
      for (int i = 0; i < P; i++) begin
        idle_gap();
        b = 8'($urandom);
        s += int'(b);
        step(1'b1, b);
      end
      if (CK) begin
        b = 8'((256 - (s % 256)) % 256);
        if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
        idle_gap();
        step(1'b1, b);
      end
      repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
    end
  endtask

  logic f0;

  initial begin
    // 44-byte frames, no sync, no checksum
    do_reset(0);
    for (int i = 0; i < 44; i++) step(1'b1, 8'(i));
    chk("dflt_msb", 352'(work_a[351:344]), 352'(8'h00));
    chk("dflt_lsb", 352'(work_a[7:0]), 352'(8'h2B));
    chk("dflt_flag", 352'(flag_a), 352'(1'b1));
    repeat (3) step(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom));
    repeat (20) step(1'b0, 8'h00);
    chk("to_errcnt", 352'(ec_a), 352'(8'd1));
    for (int i = 0; i < 44; i++) step(1'b1, 8'($urandom));
    // byte on the expiry cycle keeps the frame
    step(1'b1, 8'h77);
    repeat (15) step(1'b0, 8'h00);
    for (int i = 0; i < 43; i++) step(1'b1, 8'($urandom));
    f0 = flag_a;
    for (int i = 0; i < 88; i++) step(1'b1, 8'($urandom));
    chk("b2b_flag", 352'(flag_a), 352'(f0));
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom));
    do_reset(0);
    for (int i = 0; i < 44; i++) step(1'b1, 8'(8'hC0 + 8'(i)));
    chk("rst_flag", 352'(flag_a), 352'(1'b1));
    chk("rst_errcnt", 352'(ec_a), 352'(8'd0));
    rand_frames(15);

    // sync byte required
    do_reset(1);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'hA5);
    for (int i = 0; i < 44; i++) step(1'b1, 8'h5A);
    chk("sync_work", work_b, {44{8'h5A}});
    chk("sync_flag", 352'(flag_b), 352'(1'b1));
    rand_frames(15);

    // 4-byte payload with checksum
    do_reset(2);
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03); step(1'b1, 8'h04);
    step(1'b1, 8'hF6);
    chk("ck_good", 352'(work_c), 352'(32'h01020304));
    step(1'b1, 8'h01); step(1'b1, 8'h02); step(1'b1, 8'h03); step(1'b1, 8'h04);
    step(1'b1, 8'hF7);
    chk("ck_bad_cnt", 352'(ec_c), 352'(8'd1));
    chk("ck_bad_flag", 352'(flag_c), 352'(1'b1));
    rand_frames(60);

    // single-byte payload, sync + checksum, error count saturation
    do_reset(3);
    repeat (260) begin
      step(1'b1, 8'h3C);
      step(1'b1, 8'h10);
      step(1'b1, 8'h00);
    end
    chk("sat_cnt", 352'(ec_d), 352'(8'hFF));
    rand_frames(100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
